// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the ALU; holds instructions until both operands arrive via the CDB.
// Optional macro RS_OLDEST_FIRST_EN switches dispatch from lowest-index-ready to oldest-ready selection.
module alu_rs #(
  parameter int DEPTH   = 8,
  parameter int ROBEN_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc_valid,
  input  logic [11:0]            alloc_opcode,
  input  logic [3:0]             alloc_ALUOP,
  input  logic [ROBEN_W-1:0]     alloc_ROBEN,
  input  logic [ROBEN_W-1:0]     alloc_Qj,
  input  logic [ROBEN_W-1:0]     alloc_Qk,
  input  logic [31:0]            alloc_Vj,
  input  logic [31:0]            alloc_Vk,
  input  logic [ROBEN_W-1:0]     CDB_ROBEN,
  input  logic [31:0]            CDB_res,
  output logic [ROBEN_W-1:0]     ROBEN,
  output logic [11:0]            opcode,
  output logic [31:0]            A,
  output logic [31:0]            B,
  output logic [3:0]             ALUOP,
  output logic                   RS_full,
  output logic [$clog2(DEPTH):0] RS_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [11:0]        opcode_q [DEPTH];
  logic [11:0]        opcode_d [DEPTH];
  logic [3:0]         aluop_q  [DEPTH];
  logic [3:0]         aluop_d  [DEPTH];
  logic [ROBEN_W-1:0] roben_q  [DEPTH];
  logic [ROBEN_W-1:0] roben_d  [DEPTH];
  logic [ROBEN_W-1:0] qj_q     [DEPTH];
  logic [ROBEN_W-1:0] qj_d     [DEPTH];
  logic [ROBEN_W-1:0] qk_q     [DEPTH];
  logic [ROBEN_W-1:0] qk_d     [DEPTH];
  logic [31:0]        vj_q     [DEPTH];
  logic [31:0]        vj_d     [DEPTH];
  logic [31:0]        vk_q     [DEPTH];
  logic [31:0]        vk_d     [DEPTH];
`ifdef RS_OLDEST_FIRST_EN
  logic [7:0]         age_q    [DEPTH];
  logic [7:0]         age_d    [DEPTH];
  logic [7:0]         best_age;
`endif

  logic [ROBEN_W-1:0] out_roben_q, out_roben_d;
  logic [11:0]        out_opcode_q, out_opcode_d;
  logic [3:0]         out_aluop_q, out_aluop_d;
  logic [31:0]        out_a_q, out_a_d;
  logic [31:0]        out_b_q, out_b_d;
  logic [CW-1:0]      count_q, count_d;

  logic [DEPTH-1:0]   ready;
  logic               sel_valid;
  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      free_idx;
  logic               alloc_acc;

  // Handshake: an instruction is taken at a posedge when alloc_valid=1 and RS_full=0;
  // with RS_full=1 it is dropped, so the issue stage must hold it while RS_full is high.
  assign RS_full   = &busy_q;
  assign alloc_acc = alloc_valid & ~RS_full;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
    best_age  = '0;
    // Strict '>' keeps the lowest index on equal ages.
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!sel_valid || age_q[i] > best_age)) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
        best_age  = age_q[i];
      end
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
      end
    end
`endif
  end

  always_comb begin
    busy_d       = busy_q;
    opcode_d     = opcode_q;
    aluop_d      = aluop_q;
    roben_d      = roben_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    out_roben_d  = '0;
    out_opcode_d = '0;
    out_aluop_d  = '0;
    out_a_d      = '0;
    out_b_d      = '0;
    count_d      = count_q + CW'(alloc_acc) - CW'(sel_valid);
`ifdef RS_OLDEST_FIRST_EN
    age_d        = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && age_q[i] != 8'hFF) age_d[i] = age_q[i] + 8'd1;
    end
`endif

    // CDB snoop; a zero broadcast tag never matches.
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && CDB_ROBEN != '0) begin
        if (qj_q[i] == CDB_ROBEN) begin
          qj_d[i] = '0;
          vj_d[i] = CDB_res;
        end
        if (qk_q[i] == CDB_ROBEN) begin
          qk_d[i] = '0;
          vk_d[i] = CDB_res;
        end
      end
    end

    if (sel_valid) begin
      busy_d[sel_idx] = 1'b0;
      out_roben_d     = roben_q[sel_idx];
      out_opcode_d    = opcode_q[sel_idx];
      out_aluop_d     = aluop_q[sel_idx];
      out_a_d         = vj_q[sel_idx];
      out_b_d         = vk_q[sel_idx];
    end

    // The free slot was non-busy before the edge, so it never collides with the dispatched one.
    if (alloc_acc) begin
      busy_d[free_idx]   = 1'b1;
      opcode_d[free_idx] = alloc_opcode;
      aluop_d[free_idx]  = alloc_ALUOP;
      roben_d[free_idx]  = alloc_ROBEN;
      qj_d[free_idx]     = alloc_Qj;
      vj_d[free_idx]     = alloc_Vj;
      qk_d[free_idx]     = alloc_Qk;
      vk_d[free_idx]     = alloc_Vk;
      if (CDB_ROBEN != '0 && alloc_Qj == CDB_ROBEN) begin
        qj_d[free_idx] = '0;
        vj_d[free_idx] = CDB_res;
      end
      if (CDB_ROBEN != '0 && alloc_Qk == CDB_ROBEN) begin
        qk_d[free_idx] = '0;
        vk_d[free_idx] = CDB_res;
      end
`ifdef RS_OLDEST_FIRST_EN
      age_d[free_idx] = '0;
`endif
    end

    if (flush) begin
      busy_d       = '0;
      out_roben_d  = '0;
      out_opcode_d = '0;
      out_aluop_d  = '0;
      out_a_d      = '0;
      out_b_d      = '0;
      count_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= '0;
      out_roben_q  <= '0;
      out_opcode_q <= '0;
      out_aluop_q  <= '0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i] <= '0;
        aluop_q[i]  <= '0;
        roben_q[i]  <= '0;
        qj_q[i]     <= '0;
        qk_q[i]     <= '0;
        vj_q[i]     <= '0;
        vk_q[i]     <= '0;
`ifdef RS_OLDEST_FIRST_EN
        age_q[i]    <= '0;
`endif
      end
    end else begin
      busy_q       <= busy_d;
      out_roben_q  <= out_roben_d;
      out_opcode_q <= out_opcode_d;
      out_aluop_q  <= out_aluop_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      count_q      <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i] <= opcode_d[i];
        aluop_q[i]  <= aluop_d[i];
        roben_q[i]  <= roben_d[i];
        qj_q[i]     <= qj_d[i];
        qk_q[i]     <= qk_d[i];
        vj_q[i]     <= vj_d[i];
        vk_q[i]     <= vk_d[i];
`ifdef RS_OLDEST_FIRST_EN
        age_q[i]    <= age_d[i];
`endif
      end
    end
  end

  assign ROBEN    = out_roben_q;
  assign opcode   = out_opcode_q;
  assign ALUOP    = out_aluop_q;
  assign A        = out_a_q;
  assign B        = out_b_q;
  assign RS_count = count_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios then random traffic, checked against an entry-list model.
module tb_alu_rs;
  localparam int DEPTH   = 8;
  localparam int ROBEN_W = 5;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int OW      = ROBEN_W + 12 + 4 + 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               alloc_valid = 1'b0;
  logic [11:0]        alloc_opcode = '0;
  logic [3:0]         alloc_ALUOP = '0;
  logic [ROBEN_W-1:0] alloc_ROBEN = '0;
  logic [ROBEN_W-1:0] alloc_Qj = '0;
  logic [ROBEN_W-1:0] alloc_Qk = '0;
  logic [31:0]        alloc_Vj = '0;
  logic [31:0]        alloc_Vk = '0;
  logic [ROBEN_W-1:0] CDB_ROBEN = '0;
  logic [31:0]        CDB_res = '0;
  logic [ROBEN_W-1:0] ROBEN;
  logic [11:0]        opcode;
  logic [31:0]        A;
  logic [31:0]        B;
  logic [3:0]         ALUOP;
  logic               RS_full;
  logic [CW-1:0]      RS_count;

  alu_rs #(.DEPTH(DEPTH), .ROBEN_W(ROBEN_W)) dut (
    .clk(clk), .rst(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_opcode(alloc_opcode), .alloc_ALUOP(alloc_ALUOP),
    .alloc_ROBEN(alloc_ROBEN), .alloc_Qj(alloc_Qj), .alloc_Qk(alloc_Qk),
    .alloc_Vj(alloc_Vj), .alloc_Vk(alloc_Vk),
    .CDB_ROBEN(CDB_ROBEN), .CDB_res(CDB_res),
    .ROBEN(ROBEN), .opcode(opcode), .A(A), .B(B), .ALUOP(ALUOP),
    .RS_full(RS_full), .RS_count(RS_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: a slot list of pending instructions
  typedef struct packed {
    logic               busy;
    logic [11:0]        op;
    logic [3:0]         aluop;
    logic [ROBEN_W-1:0] rob;
    logic [ROBEN_W-1:0] qj;
    logic [ROBEN_W-1:0] qk;
    logic [31:0]        vj;
    logic [31:0]        vk;
    logic [7:0]         age;
  } ent_t;

  ent_t          m [DEPTH];
  logic [OW-1:0] exp_q [$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].busy) n++;
    return n;
  endfunction

  // Applies one clock edge to the model using the currently driven inputs.
  function automatic void model_edge();
    int sel = -1;
    int fr  = -1;
    int n   = 0;
    logic [OW-1:0] o = '0;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back('0);
      return;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
      exp_q.push_back('0);
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy) n++;
      else if (fr < 0) fr = i;
      if (m[i].busy && m[i].qj == 0 && m[i].qk == 0) begin
`ifdef RS_OLDEST_FIRST_EN
        if (sel < 0 || m[i].age > m[sel].age) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    if (sel >= 0) o = {m[sel].rob, m[sel].op, m[sel].aluop, m[sel].vj, m[sel].vk};
    exp_q.push_back(o);
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy) begin
        if (m[i].age != 8'hFF) m[i].age = m[i].age + 8'd1;
        if (CDB_ROBEN != 0 && m[i].qj == CDB_ROBEN) begin m[i].qj = '0; m[i].vj = CDB_res; end
        if (CDB_ROBEN != 0 && m[i].qk == CDB_ROBEN) begin m[i].qk = '0; m[i].vk = CDB_res; end
      end
    end
    if (sel >= 0) m[sel].busy = 1'b0;
    if (alloc_valid && n < DEPTH) begin
      m[fr].busy  = 1'b1;
      m[fr].op    = alloc_opcode;
      m[fr].aluop = alloc_ALUOP;
      m[fr].rob   = alloc_ROBEN;
      m[fr].qj    = alloc_Qj;
      m[fr].vj    = alloc_Vj;
      m[fr].qk    = alloc_Qk;
      m[fr].vk    = alloc_Vk;
      m[fr].age   = '0;
      if (CDB_ROBEN != 0 && alloc_Qj == CDB_ROBEN) begin m[fr].qj = '0; m[fr].vj = CDB_res; end
      if (CDB_ROBEN != 0 && alloc_Qk == CDB_ROBEN) begin m[fr].qk = '0; m[fr].vk = CDB_res; end
    end
  endfunction

  // Driver tasks
  task automatic drive_alloc(input int rob, input int qj, input logic [31:0] vj,
                             input int qk, input logic [31:0] vk,
                             input logic [3:0] aop, input logic [11:0] op);
    alloc_valid  = 1'b1;
    alloc_ROBEN  = ROBEN_W'(rob);
    alloc_Qj     = ROBEN_W'(qj);
    alloc_Vj     = vj;
    alloc_Qk     = ROBEN_W'(qk);
    alloc_Vk     = vk;
    alloc_ALUOP  = aop;
    alloc_opcode = op;
  endtask

  task automatic drive_cdb(input int tag, input logic [31:0] res);
    CDB_ROBEN = ROBEN_W'(tag);
    CDB_res   = res;
  endtask

  task automatic drive_idle();
    alloc_valid = 1'b0;
    flush       = 1'b0;
    CDB_ROBEN   = '0;
    CDB_res     = '0;
  endtask

  // One clock: model predicts, DUT advances, scoreboard compares 1 ns after the edge.
  task automatic step();
    logic [OW-1:0] e;
    int cnt;
    model_edge();
    @(posedge clk);
    #1;
    cnt = model_count();
    e = exp_q.pop_front();
    chk("dispatch", {ROBEN, opcode, ALUOP, A, B}, e);
    chk("rs_count", OW'(RS_count), OW'(cnt));
    chk("rs_full", OW'(RS_full), OW'(cnt == DEPTH));
    drive_idle();
  endtask

  initial begin
    model_reset();
    // Reset held for three edges, then idle
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("idle_roben", OW'(ROBEN), OW'(0));

    // Ready instruction dispatches one edge after allocation
    drive_alloc(3, 0, 32'd5, 0, 32'd7, 4'h0, 12'h033);
    step();
    step();
    chk("ready_roben", OW'(ROBEN), OW'(3));
    chk("ready_a", OW'(A), OW'(5));
    chk("ready_b", OW'(B), OW'(7));
    step();
    chk("ready_bubble", OW'(ROBEN), OW'(0));

    // CDB wakeup two cycles after allocation
    drive_alloc(4, 2, 32'hDEAD, 0, 32'd9, 4'h3, 12'h063);
    step();
    step();
    drive_cdb(2, 32'h10);
    step();
    step();
    chk("wake_roben", OW'(ROBEN), OW'(4));
    chk("wake_a", OW'(A), OW'(32'h10));
    chk("wake_b", OW'(B), OW'(9));

    // Same-cycle allocation bypass
    drive_alloc(5, 2, 32'hBEEF, 0, 32'd1, 4'h1, 12'h013);
    drive_cdb(2, 32'h20);
    step();
    step();
    chk("bypass_roben", OW'(ROBEN), OW'(5));
    chk("bypass_a", OW'(A), OW'(32'h20));

    // Fill all entries, overflow, then drain in order
    for (int k = 0; k < DEPTH; k++) begin
      drive_alloc(10 + k, 7, 32'd0, 0, 32'(100 + k), 4'(k), 12'h033);
      step();
    end
    chk("full_count", OW'(RS_count), OW'(DEPTH));
    chk("full_flag", OW'(RS_full), OW'(1));
    drive_alloc(20, 0, 32'd1, 0, 32'd2, 4'h2, 12'h033);
    step();
    chk("overflow_count", OW'(RS_count), OW'(DEPTH));
    drive_cdb(7, 32'h77);
    step();
    for (int k = 0; k < DEPTH; k++) begin
      step();
      chk("drain_roben", OW'(ROBEN), OW'(10 + k));
      chk("drain_count", OW'(RS_count), OW'(DEPTH - 1 - k));
    end
    step();

    // Flush with a ready entry and a concurrent allocation
    drive_alloc(21, 6, 32'd0, 0, 32'd1, 4'h0, 12'h033);
    step();
    drive_alloc(22, 0, 32'd0, 6, 32'd1, 4'h0, 12'h033);
    step();
    drive_alloc(23, 0, 32'd3, 0, 32'd4, 4'h5, 12'h033);
    step();
    flush = 1'b1;
    drive_alloc(24, 0, 32'd8, 0, 32'd8, 4'h0, 12'h033);
    step();
    chk("flush_roben", OW'(ROBEN), OW'(0));
    chk("flush_count", OW'(RS_count), OW'(0));
    step();
    drive_cdb(6, 32'h66);
    step();
    step();
    chk("flush_no_wake", OW'(ROBEN), OW'(0));

    // Asynchronous reset between edges while a dispatch is on the outputs
    drive_alloc(25, 9, 32'd0, 0, 32'd1, 4'h0, 12'h033);
    step();
    drive_alloc(26, 0, 32'h55, 0, 32'h66, 4'h7, 12'h0AB);
    step();
    step();
    chk("pre_reset_roben", OW'(ROBEN), OW'(26));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_roben", OW'(ROBEN), OW'(0));
    chk("async_a", OW'(A), OW'(0));
    chk("async_b", OW'(B), OW'(0));
    chk("async_aluop", OW'(ALUOP), OW'(0));
    chk("async_count", OW'(RS_count), OW'(0));
    chk("async_full", OW'(RS_full), OW'(0));
    step();
    rst_n = 1'b1;
    step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1)
        drive_alloc($urandom_range(1, 31),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0, $urandom(),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0, $urandom(),
                    4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)));
      if ($urandom_range(0, 1) == 1)
        drive_cdb($urandom_range(0, 6), $urandom());
      step();
    end
    for (int c = 0; c < 24; c++) begin
      drive_cdb(1 + (c % 6), $urandom());
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
